// File: rtl/cla_sequencer.sv
// cla_sequencer: multi-cycle WIDTH-bit adder/subtractor built from one 4-bit
// carry-lookahead slice, stepped over WIDTH/4 nibbles LSB first. The carry
// out of each step is held in a register and fed to the next step, so the
// critical path is one slice plus the nibble select.

// 4-bit carry-lookahead slice: all internal carries are flat sum-of-products
// of generate/propagate terms, so no carry ripples inside the slice.
module cla_slice_4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_c0,
  output logic [3:0] o_s,
  output logic       o_c4
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  assign w_c[0] = i_c0;
  assign w_c[1] = w_g[0] | (w_p[0] & i_c0);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_c0);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_c0);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_c0);

  assign o_s  = w_p ^ w_c[3:0];
  assign o_c4 = w_c[4];

endmodule

module cla_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int N  = WIDTH / 4;
  localparam int KW = $clog2(N);
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic             r_cr;
  logic [KW-1:0]    r_k;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;

  logic [KW+1:0]    w_base;
  logic [3:0]       w_s;
  logic             w_c4;

  // Bit offset of the current nibble; k*4 is just k shifted left by two.
  assign w_base = {r_k, 2'b00};

  cla_slice_4 u_slice (
    .i_a  (r_opa[w_base +: 4]),
    .i_b  (r_opb[w_base +: 4]),
    .i_c0 (r_cr),
    .o_s  (w_s),
    .o_c4 (w_c4)
  );

  // Control FSM and datapath registers; every output is a register.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_opa   <= '0;
      r_opb   <= '0;
      r_cr    <= 1'b0;
      r_k     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (start) begin
            // Subtraction is a + ~b + 1: invert B once here and force the carry.
            r_opa   <= a;
            r_opb   <= sub ? ~b : b;
            r_cr    <= sub | cin;
            r_k     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_sum[w_base +: 4] <= w_s;
          r_cr               <= w_c4;
          if (r_k == K_LAST) begin
            // Same-sign operands whose result flips sign have overflowed.
            r_cout  <= w_c4;
            r_ovf   <= (r_opa[WIDTH-1] == r_opb[WIDTH-1]) && (w_s[3] != r_opa[WIDTH-1]);
            r_k     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_k <= r_k + KW'(1);
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign sum      = r_sum;
  assign cout     = r_cout;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_cla_sequencer.sv
// Self-checking bench for cla_sequencer (WIDTH=32). Expected results come
// from plain 33-bit / signed 64-bit arithmetic, or from literal constants for
// the directed cases.
module tb_cla_sequencer;

  localparam int W = 32;
  localparam int N = W / 4;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic         cin;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_sum;
  logic         exp_cout;
  logic         exp_ovf;

  cla_sequencer #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Reference: a +/- b as integers; unsigned result mod 2^32, carry/no-borrow, signed range test.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic ms,
                       input logic mc, output logic [W-1:0] rs, output logic rc,
                       output logic ro);
    logic [W:0] full;
    longint sa;
    longint sb;
    longint r;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    if (ms) begin
      full = {1'b0, ma} - {1'b0, mb};
      rc   = (ma >= mb);
      r    = sa - sb;
    end else begin
      full = {1'b0, ma} + {1'b0, mb} + {32'd0, mc};
      rc   = full[W];
      r    = sa + sb + longint'(mc);
    end
    rs = full[W-1:0];
    ro = (r > SMAX) || (r < SMIN);
  endtask

  // Drive a request at the current negedge and compute the expected result.
  task automatic launch(input logic [W-1:0] la, input logic [W-1:0] lb,
                        input logic ls, input logic lc);
    a     = la;
    b     = lb;
    sub   = ls;
    cin   = lc;
    start = 1'b1;
    model(la, lb, ls, lc, exp_sum, exp_cout, exp_ovf);
  endtask

  // Called at the negedge where launch() ran. Walks the N+1 cycles after the
  // accepting edge, ending on the negedge where done should be high.
  task automatic finish_op(input string name, input bit hold);
    int busy_cnt;
    int done_cnt;
    int done_at;
    bit both;
    bit cleared;
    busy_cnt = 0;
    done_cnt = 0;
    done_at  = 0;
    both     = 1'b0;
    cleared  = 1'b0;
    @(negedge clk);
    if (!hold) start = 1'b0;
    for (int idx = 1; idx <= N + 1; idx++) begin
      if (idx == 1) cleared = (sum === '0) && (cout === 1'b0) && (overflow === 1'b0);
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_at == 0) done_at = idx;
      end
      if (busy === 1'b1 && done === 1'b1) both = 1'b1;
      if (hold) begin
        a   = $urandom;
        b   = $urandom;
        sub = 1'($urandom);
        cin = 1'($urandom);
      end
      if (idx <= N) @(negedge clk);
    end
    if (hold) start = 1'b0;

    checks++;
    if (cleared !== 1'b1) begin
      errors++;
      $display("FAIL %s clear-on-start: sum=%h cout=%b ovf=%b after accept, required all 0",
               name, sum, cout, overflow);
    end
    checks++;
    if (busy_cnt != N || both) begin
      errors++;
      $display("FAIL %s busy: %0d cycles (overlap with done=%b), required %0d and no overlap",
               name, busy_cnt, both, N);
    end
    checks++;
    if (done_at != N + 1 || done_cnt != 1) begin
      errors++;
      $display("FAIL %s done: first at cycle %0d count %0d, required cycle %0d count 1",
               name, done_at, done_cnt, N + 1);
    end
    checks++;
    if (sum !== exp_sum || cout !== exp_cout || overflow !== exp_ovf) begin
      errors++;
      $display("FAIL %s result: sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
               name, sum, cout, overflow, exp_sum, exp_cout, exp_ovf);
    end
  endtask

  // Confirm the block is back in IDLE with outputs held.
  task automatic expect_idle(input string name);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== exp_sum) begin
      errors++;
      $display("FAIL %s idle: busy=%b done=%b sum=%h, required busy=0 done=0 sum=%h",
               name, busy, done, sum, exp_sum);
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    cin   = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b sum=%h cout=%b ovf=%b, required all 0",
               busy, done, sum, cout, overflow);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Each directed case overrides the model with literal expected values.
  task automatic directed(input string name, input logic [W-1:0] da, input logic [W-1:0] db,
                          input logic ds, input logic dc, input logic [W-1:0] es,
                          input logic ec, input logic eo);
    launch(da, db, ds, dc);
    exp_sum  = es;
    exp_cout = ec;
    exp_ovf  = eo;
    finish_op(name, 1'b0);
    expect_idle(name);
  endtask

  task automatic test_directed();
    directed("ripple",    32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    directed("ovf_pos",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    directed("ovf_neg",   32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
    directed("sub_small", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    directed("sub_ovf",   32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
    directed("add_cin",   32'h0000_000F, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0010, 1'b0, 1'b0);
  endtask

  // start stays high through RUN while operands churn; only the first set counts.
  task automatic test_start_held();
    launch(32'hDEAD_BEEF, 32'h0123_4567, 1'b0, 1'b1);
    finish_op("start_held", 1'b1);
    expect_idle("start_held");
  endtask

  // A start in DONE begins the next run with no IDLE cycle in between.
  task automatic test_back_to_back();
    launch(32'h0F0F_0F0F, 32'hF0F0_F0F1, 1'b0, 1'b0);
    finish_op("b2b_first", 1'b0);
    launch(32'h0000_1000, 32'h0000_2000, 1'b1, 1'b0);
    finish_op("b2b_second", 1'b0);
    expect_idle("b2b_second");
  endtask

  // Abort at the 4th RUN cycle, then a fresh operation must complete normally.
  task automatic test_reset_mid();
    launch(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b sum=%h cout=%b ovf=%b, required all 0",
               busy, done, sum, cout, overflow);
    end
    repeat (N + 2) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_quiet: busy=%b done=%b after abort, required 0 0", busy, done);
      end
    end
    launch(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    exp_sum  = 32'h2345_6789;
    exp_cout = 1'b0;
    exp_ovf  = 1'b0;
    finish_op("after_reset", 1'b0);
    expect_idle("after_reset");
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Random add/sub, randomly mixing back-to-back and idle-separated requests.
  task automatic test_random();
    for (int i = 0; i < 1000; i++) begin
      launch(pick_operand(), pick_operand(), 1'($urandom), 1'($urandom));
      finish_op("random", 1'b0);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    expect_idle("random_end");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_held();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cla_sequencer.md
# cla_sequencer

Multi-cycle wide adder/subtractor. A single 4-bit carry-lookahead adder slice (CarryLookaheadAdder4bits) is time-multiplexed across WIDTH/4 nibbles, least-significant first. The block latches both operands, steps the slice once per clock while carrying c4 forward in a register, and presents the full result with a start/done handshake. It trades latency for area and serves as the shared add/sub resource for later multi-cycle datapath blocks.

## Interface
- WIDTH, 32: operand width in bits. Must be a multiple of 4 and at least 8. N = WIDTH/4 nibble steps.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request pulse. Sampled only in IDLE or DONE.
- sub  in  1  0: compute a + b + cin. 1: compute a - b (a + ~b + 1; cin ignored). Sampled with start.
- a  in  WIDTH  operand A. Sampled with start.
- b  in  WIDTH  operand B. Sampled with start.
- cin  in  1  carry-in for add. Sampled with start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; result valid.
- sum  out  WIDTH  result register.
- cout  out  1  carry out of the MSB nibble. For sub, 1 means no borrow.
- overflow  out  1  two's-complement signed overflow of the operation.

## Operation
- States:
  - IDLE: reset state.
  - RUN: stepping nibbles.
  - DONE: single cycle.
- On an accepted start (IDLE or DONE, start=1):
  - Latch opa = a and opb = sub ? ~b : b.
  - Load carry register cr = sub ? 1 : cin.
  - Clear nibble index k to 0.
  - Clear the sum register to 0.
  - Go to RUN.
- RUN, each cycle:
  - Drive the slice with opa[4k+3:4k], opb[4k+3:4k] and cr.
  - On the clock edge, write the slice output s into sum[4k+3:4k] and load its c4 into cr.
  - Increment k.
  - When k = N-1: go to DONE, load cout from c4, and compute overflow as (opa[W-1] == opb[W-1]) && (new sum[W-1] != opa[W-1]).
- DONE: done = 1 for exactly one cycle.
  - If start is high in this cycle, it is accepted (back-to-back) and the state goes to RUN.
  - Otherwise the state goes to IDLE.
- start while in RUN is ignored. No queuing, no error flag.
- Inputs a, b, sub and cin may change freely after the accepting edge; only the latched copies are used.
- sum, cout and overflow hold their last values until the next accepted start.
  - Accepting a start clears sum, cout and overflow to 0.
  - Intermediate nibbles become visible in sum as they complete. Consumers must qualify sum with done.
- k is a ceil(log2 N)-bit counter and never wraps inside an operation. Arithmetic is modulo 2^WIDTH; carry beyond the MSB appears only in cout.

## Timing
- Reset values: state IDLE, busy 0, done 0, sum 0, cout 0, overflow 0, k 0, cr 0.
- rst has priority over every other input in every state. Asserting rst mid-RUN aborts the operation: outputs return to their reset values on that edge and no done is produced.
- Latency: with start sampled at edge E0, busy is high for the N cycles after E0. done is high in the cycle after edge EN (N+1 edges from E0 to first done-high edge sample). For WIDTH=32 that is 8 RUN cycles.
- Throughput: one operation per N+1 cycles using back-to-back starts in DONE.
- busy and done are never high simultaneously. busy=0 and done=0 in IDLE.
- The critical path is one 4-bit CLA slice plus the nibble mux; there is no combinational path from inputs to outputs.

## Test plan
- Carry ripple across all nibbles (WIDTH=32): a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0 -> after 8 busy cycles, done pulse; sum=0x00000000, cout=1, overflow=0.
- Signed overflow: a=0x7FFFFFFF, b=0x00000001, sub=0 -> sum=0x80000000, cout=0, overflow=1. Then a=0x80000000, b=0x80000000 -> sum=0, cout=1, overflow=1.
- Subtract: a=5, b=7, sub=1, cin=1 (ignored) -> sum=0xFFFFFFFE, cout=0, overflow=0. Then a=0x80000000, b=1, sub=1 -> sum=0x7FFFFFFF, cout=1, overflow=1.
- Handshake:
  - start held high continuously through RUN with different a/b values -> result reflects only the first latched operands.
  - start high in DONE -> a new RUN begins with no IDLE cycle; done pulses exactly once per operation.
- Reset mid-operation: assert rst for one cycle at the 4th RUN cycle -> next cycle busy=0, done=0, sum=0, cout=0. A fresh start of a=0x12345678, b=0x11111111 then yields sum=0x23456789, cout=0.
- Add with carry-in: a=0x0000000F, b=0, cin=1 -> sum=0x00000010. Randomised 1000 add/sub pairs checked against a 33-bit reference sum and signed-overflow model.
